// File: rtl/behav_counter_param.sv
// rtl/behav_counter_param.sv - parameterised up/down counter with wrap or saturate at 0..LIMIT
// Optional sticky overflow/underflow flags are built when BEHAV_COUNTER_STICKY_EN is defined.
module behav_counter_param #(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned LIMIT    = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             sync_clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             up_down,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] qd,
    output logic             tc,
`ifdef BEHAV_COUNTER_STICKY_EN
    input  logic             flag_clr,
    output logic             ovf,
    output logic             unf,
`endif
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] LIM_W = WIDTH'(LIMIT);
    localparam logic [WIDTH:0]   LIM_X = (WIDTH+1)'(LIMIT);
    localparam logic [WIDTH:0]   MOD_X = LIM_X + (WIDTH+1)'(1);

    logic [WIDTH-1:0] step_eff;
    logic [WIDTH:0]   q_x;
    logic [WIDTH:0]   s_x;
    logic [WIDTH:0]   sum_x;
    logic [WIDTH-1:0] cnt_next;
    logic             cnt_oor;

    // Unsupported steps above LIMIT are clamped so every result stays in 0..LIMIT.
    always_comb begin
        step_eff = (step > LIM_W) ? LIM_W : step;
        q_x      = {1'b0, qd};
        s_x      = {1'b0, step_eff};
        sum_x    = q_x + s_x;
        cnt_next = qd;
        cnt_oor  = 1'b0;
        if (up_down) begin
            if (sum_x > LIM_X) begin
                cnt_oor  = 1'b1;
                cnt_next = SATURATE ? LIM_W : WIDTH'(sum_x - MOD_X);
            end else begin
                cnt_next = WIDTH'(sum_x);
            end
        end else begin
            if (s_x <= q_x) begin
                cnt_next = WIDTH'(q_x - s_x);
            end else begin
                cnt_oor  = 1'b1;
                cnt_next = SATURATE ? '0 : WIDTH'(q_x + MOD_X - s_x);
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            qd <= '0;
            tc <= 1'b0;
        end else if (sync_clr) begin
            qd <= '0;
            tc <= 1'b0;
        end else if (load) begin
            qd <= (d > LIM_W) ? LIM_W : d;
            tc <= 1'b0;
        end else if (en) begin
            qd <= cnt_next;
            tc <= cnt_oor;
        end else begin
            tc <= 1'b0;
        end
    end

`ifdef BEHAV_COUNTER_STICKY_EN
    logic count_evt;

    assign count_evt = !sync_clr && !load && en && cnt_oor;

    // A new event in the same cycle as flag_clr wins; sync_clr leaves the flags alone.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (count_evt && up_down) begin
                ovf <= 1'b1;
            end else if (flag_clr) begin
                ovf <= 1'b0;
            end
            if (count_evt && !up_down) begin
                unf <= 1'b1;
            end else if (flag_clr) begin
                unf <= 1'b0;
            end
        end
    end
`endif

    assign at_max = (qd == LIM_W);
    assign at_min = (qd == '0);

endmodule

// File: tb/tb_behav_counter_param.sv
// tb/tb_behav_counter_param.sv - self-checking bench for behav_counter_param (wrap and saturate instances)
// Sticky-flag checks are compiled in when BEHAV_COUNTER_STICKY_EN is defined.
module tb_behav_counter_param;

    localparam int W = 8;
    localparam int L = 9;
    localparam int M = L + 1;

    logic         clk = 1'b0;
    logic         clear_n;
    logic         sync_clr;
    logic         load;
    logic [W-1:0] d;
    logic         en;
    logic         up_down;
    logic [W-1:0] step;
    logic         flag_clr;

    logic [W-1:0] qd_w, qd_s;
    logic         tc_w, tc_s;
    logic         at_max_w, at_max_s, at_min_w, at_min_s;
    logic         ovf_w, unf_w, ovf_s, unf_s;

    int n_asserts = 0;
    int n_fails   = 0;

    int m_qw, m_qs;
    bit m_tcw, m_tcs, m_ovfw, m_unfw, m_ovfs, m_unfs;

    always #5 clk = ~clk;

    behav_counter_param #(.WIDTH(W), .LIMIT(L), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .clear_n(clear_n), .sync_clr(sync_clr), .load(load), .d(d),
        .en(en), .up_down(up_down), .step(step), .qd(qd_w), .tc(tc_w),
`ifdef BEHAV_COUNTER_STICKY_EN
        .flag_clr(flag_clr), .ovf(ovf_w), .unf(unf_w),
`endif
        .at_max(at_max_w), .at_min(at_min_w)
    );

    behav_counter_param #(.WIDTH(W), .LIMIT(L), .SATURATE(1'b1)) u_sat (
        .clk(clk), .clear_n(clear_n), .sync_clr(sync_clr), .load(load), .d(d),
        .en(en), .up_down(up_down), .step(step), .qd(qd_s), .tc(tc_s),
`ifdef BEHAV_COUNTER_STICKY_EN
        .flag_clr(flag_clr), .ovf(ovf_s), .unf(unf_s),
`endif
        .at_max(at_max_s), .at_min(at_min_s)
    );

`ifndef BEHAV_COUNTER_STICKY_EN
    assign ovf_w = 1'b0;
    assign unf_w = 1'b0;
    assign ovf_s = 1'b0;
    assign unf_s = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: modular arithmetic on the range 0..L, or clamping when saturating.
    task automatic model(input bit sat, inout int q, inout bit tc, inout bit ovf, inout bit unf);
        bit ev_up = 1'b0;
        bit ev_dn = 1'b0;
        int raw;
        if (sync_clr) begin
            q = 0; tc = 1'b0;
        end else if (load) begin
            q = (int'(d) > L) ? L : int'(d); tc = 1'b0;
        end else if (en) begin
            raw = up_down ? q + int'(step) : q - int'(step);
            if (raw > L || raw < 0) begin
                tc = 1'b1;
                ev_up = up_down;
                ev_dn = !up_down;
                if (sat) q = (raw > L) ? L : 0;
                else     q = ((raw % M) + M) % M;
            end else begin
                q = raw; tc = 1'b0;
            end
        end else begin
            tc = 1'b0;
        end
        ovf = ev_up ? 1'b1 : (flag_clr ? 1'b0 : ovf);
        unf = ev_dn ? 1'b1 : (flag_clr ? 1'b0 : unf);
    endtask

    task automatic model_reset();
        m_qw = 0; m_qs = 0;
        m_tcw = 0; m_tcs = 0;
        m_ovfw = 0; m_unfw = 0; m_ovfs = 0; m_unfs = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".qd_w"},     32'(qd_w),     32'(m_qw));
        check({tag, ".tc_w"},     32'(tc_w),     32'(m_tcw));
        check({tag, ".at_max_w"}, 32'(at_max_w), 32'(m_qw == L));
        check({tag, ".at_min_w"}, 32'(at_min_w), 32'(m_qw == 0));
        check({tag, ".qd_s"},     32'(qd_s),     32'(m_qs));
        check({tag, ".tc_s"},     32'(tc_s),     32'(m_tcs));
        check({tag, ".at_max_s"}, 32'(at_max_s), 32'(m_qs == L));
        check({tag, ".at_min_s"}, 32'(at_min_s), 32'(m_qs == 0));
`ifdef BEHAV_COUNTER_STICKY_EN
        check({tag, ".ovf_w"}, 32'(ovf_w), 32'(m_ovfw));
        check({tag, ".unf_w"}, 32'(unf_w), 32'(m_unfw));
        check({tag, ".ovf_s"}, 32'(ovf_s), 32'(m_ovfs));
        check({tag, ".unf_s"}, 32'(unf_s), 32'(m_unfs));
`endif
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        model(1'b0, m_qw, m_tcw, m_ovfw, m_unfw);
        model(1'b1, m_qs, m_tcs, m_ovfs, m_unfs);
        check_all(tag);
    endtask

    task automatic set_in(input bit sc, input bit ld, input int dv, input bit e, input bit ud, input int st);
        sync_clr = sc; load = ld; d = W'(dv); en = e; up_down = ud; step = W'(st);
    endtask

    initial begin
        clear_n = 1'b0; flag_clr = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        clear_n = 1'b1;

        // Count to 5, then assert reset between edges while still enabled.
        set_in(0, 0, 0, 1, 1, 1);
        repeat (5) tick("count5");
        check("count5.final", 32'(qd_w), 32'd5);
        @(posedge clk);
        #1;
        model(1'b0, m_qw, m_tcw, m_ovfw, m_unfw);
        model(1'b1, m_qs, m_tcs, m_ovfs, m_unfs);
        #2;
        clear_n = 1'b0;
        #1;
        model_reset();
        check("async.qd", 32'(qd_w), 32'd0);
        check("async.tc", 32'(tc_w), 32'd0);
        check("async.at_min", 32'(at_min_w), 32'd1);
        check_all("async");
        #3;
        clear_n = 1'b1;
        tick("post_reset");
        check("post_reset.qd", 32'(qd_w), 32'd1);

        // Wrap-up 7,8,9,0,1.
        set_in(0, 1, 7, 0, 0, 0);
        tick("wrap_up.load");
        set_in(0, 0, 0, 1, 1, 1);
        tick("wrap_up.8");
        tick("wrap_up.9");
        check("wrap_up.9.at_max", 32'(at_max_w), 32'd1);
        tick("wrap_up.0");
        check("wrap_up.0.qd", 32'(qd_w), 32'd0);
        check("wrap_up.0.tc", 32'(tc_w), 32'd1);
        tick("wrap_up.1");
        check("wrap_up.1.tc", 32'(tc_w), 32'd0);

        // Wrap-down and load clamping.
        set_in(0, 1, 1, 0, 0, 0);
        tick("wrap_dn.load");
        set_in(0, 0, 0, 1, 0, 3);
        tick("wrap_dn");
        check("wrap_dn.qd", 32'(qd_w), 32'd8);
        check("wrap_dn.tc", 32'(tc_w), 32'd1);
        set_in(0, 1, 200, 1, 1, 2);
        tick("load_clamp");
        check("load_clamp.qd", 32'(qd_w), 32'd9);
        check("load_clamp.tc", 32'(tc_w), 32'd0);
        set_in(1, 1, 5, 1, 1, 2);
        tick("clr_over_load");
        check("clr_over_load.qd", 32'(qd_w), 32'd0);

        // Saturation at the top, then hold with en low.
        set_in(0, 1, 7, 0, 0, 0);
        tick("sat.load");
        set_in(0, 0, 0, 1, 1, 4);
        tick("sat.hit");
        check("sat.hit.qd", 32'(qd_s), 32'd9);
        check("sat.hit.tc", 32'(tc_s), 32'd1);
        tick("sat.again");
        check("sat.again.tc", 32'(tc_s), 32'd1);
        set_in(0, 0, 0, 0, 1, 4);
        tick("sat.idle");
        check("sat.idle.qd", 32'(qd_s), 32'd9);
        check("sat.idle.tc", 32'(tc_s), 32'd0);
        set_in(0, 0, 0, 1, 0, 0);
        tick("step0");

`ifdef BEHAV_COUNTER_STICKY_EN
        set_in(0, 1, 9, 0, 0, 0);
        tick("sticky.load");
        set_in(0, 0, 0, 1, 1, 1);
        tick("sticky.ovf");
        check("sticky.ovf.ovf", 32'(ovf_w), 32'd1);
        check("sticky.ovf.unf", 32'(unf_w), 32'd0);
        set_in(1, 0, 0, 0, 0, 0);
        tick("sticky.sync_clr");
        check("sticky.sync_clr.ovf", 32'(ovf_w), 32'd1);
        flag_clr = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        tick("sticky.clr");
        check("sticky.clr.ovf", 32'(ovf_w), 32'd0);
        set_in(0, 0, 0, 1, 0, 1);
        tick("sticky.clr_vs_unf");
        check("sticky.clr_vs_unf.unf", 32'(unf_w), 32'd1);
        check("sticky.clr_vs_unf.qd", 32'(qd_w), 32'd9);
        flag_clr = 1'b0;
`endif

        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(99, 0);
            set_in(r < 3, (r >= 3) && (r < 10), $urandom_range(255, 0),
                   $urandom_range(3, 0) != 0, $urandom_range(1, 0) != 0, $urandom_range(L, 0));
            flag_clr = ($urandom_range(7, 0) == 0);
            tick("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
